// File: rtl/tone_seq_pkg.sv
// tone_seq_pkg: state encoding, ROM entry layout and base amplitude shared by the
// tone_sequencer top and its tone generator.
package tone_seq_pkg;
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, GAP, DONE} state_t;
    localparam int DUR_W = 4;
    localparam int HP_W = 20;
    localparam int HP_LSB = 0;
    localparam int DUR_LSB = HP_LSB + HP_W;
    localparam int ENTRY_W = DUR_W + HP_W;
    localparam logic [15:0] BASE_AMP = 16'h0800;
    function automatic logic [15:0] amp_of(input logic [1:0] vol);
        return BASE_AMP << vol;
    endfunction
endpackage

// File: rtl/tone_gen.sv
// tone_gen: half-period counter, phase register and registered square-wave sample.
// Clear starts a note with phase high; enable advances one played cycle, otherwise the sample is muted.
module tone_gen import tone_seq_pkg::*; (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_en,
    input  logic            i_clr,
    input  logic [HP_W-1:0] i_half_period,
    input  logic [15:0]     i_amp,
    output logic [15:0]     o_sample
);
    logic [HP_W-1:0] r_cnt;
    logic            r_phase;
    logic [15:0]     r_sample;
    logic            w_rest, w_wrap, w_phase_n;

    assign w_rest = i_half_period == '0;
    assign w_wrap = !w_rest && r_cnt == i_half_period - HP_W'(1);
    assign w_phase_n = i_clr ? 1'b1 : (i_en && w_wrap) ? ~r_phase : r_phase;
    assign o_sample = r_sample;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_phase <= 1'b0;
            r_sample <= '0;
        end else begin
            r_cnt <= i_clr ? '0 : (i_en && !w_rest) ? (w_wrap ? '0 : r_cnt + 1'b1) : r_cnt;
            r_phase <= w_phase_n;
            r_sample <= ((i_clr || i_en) && !w_rest) ? (w_phase_n ? i_amp : -i_amp) : '0;
        end
    end
endmodule

// File: rtl/tone_sequencer.sv
// tone_sequencer: walks a melody ROM of {dur, half_period} entries and emits registered
// square-wave samples, handling per-note duration, inter-note gap, looping, pause and stop.
module tone_sequencer import tone_seq_pkg::*; #(
    parameter int BEAT_CYCLES = 12_500_000,
    parameter int GAP_CYCLES  = 1_000_000,
    parameter int ADDR_W      = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    input  logic               loop,
    input  logic [1:0]         volume,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [ENTRY_W-1:0] rom_data,
    output logic [15:0]        audio_left,
    output logic [15:0]        audio_right,
    output logic               busy,
    output logic               done
);
    localparam int CW = $clog2((BEAT_CYCLES > GAP_CYCLES ? BEAT_CYCLES : GAP_CYCLES) + 1);

    state_t            r_state, w_next, w_end;
    logic [ADDR_W-1:0] r_addr;
    logic [DUR_W-1:0]  r_beat, w_dur;
    logic [CW-1:0]     r_cyc;
    logic [HP_W-1:0]   r_hp, w_hp, w_tg_hp;
    logic [15:0]       r_amp, w_tg_amp, w_sample;
    logic              r_busy, r_done, w_tick, w_beat_wrap, w_last;
    logic              w_tg_en, w_tg_clr, w_busy_n, w_done_n;

    assign w_dur = rom_data[DUR_LSB +: DUR_W];
    assign w_hp = rom_data[HP_LSB +: HP_W];
    assign w_last = &r_addr;
    assign w_end = loop ? FETCH : DONE;
    assign w_tick = (r_state == PLAY || r_state == GAP) && !pause;
    assign w_beat_wrap = r_cyc == CW'(BEAT_CYCLES - 1);

    always_ff @(posedge clk) begin
        r_state <= rst ? IDLE : w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start ? FETCH : IDLE;
            FETCH:   w_next = LOAD;
            LOAD:    w_next = (w_dur == '0) ? w_end : PLAY;
            PLAY:    w_next = (w_tick && w_beat_wrap && r_beat == DUR_W'(1)) ? GAP : PLAY;
            GAP:     w_next = (w_tick && r_cyc == CW'(GAP_CYCLES - 1)) ? (w_last ? w_end : FETCH) : GAP;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (stop) w_next = IDLE;
    end

    // busy/done trail the DONE state by one cycle so the pulse lands after the last fetch
    always_comb begin
        w_tg_clr = r_state == LOAD && w_next == PLAY;
        w_tg_en = r_state == PLAY && w_next == PLAY && !pause;
        w_tg_hp = (r_state == LOAD) ? w_hp : r_hp;
        w_tg_amp = (r_state == LOAD) ? amp_of(volume) : r_amp;
        w_busy_n = w_next != IDLE || (r_state == DONE && !stop);
        w_done_n = r_state == DONE && !stop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr <= '0;
            r_beat <= '0;
            r_cyc <= '0;
            r_hp <= '0;
            r_amp <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_addr <= (w_next == FETCH) ? ((r_state == GAP && !w_last) ? r_addr + 1'b1 : '0)
                                        : (w_next == IDLE ? '0 : r_addr);
            r_beat <= (r_state == LOAD) ? w_dur
                    : (w_tick && r_state == PLAY && w_beat_wrap) ? r_beat - 1'b1 : r_beat;
            r_cyc <= (r_state != w_next) ? '0 : !w_tick ? r_cyc
                   : (r_state == PLAY && w_beat_wrap) ? '0 : r_cyc + 1'b1;
            if (r_state == LOAD) begin
                r_hp <= w_hp;
                r_amp <= amp_of(volume);
            end
            r_busy <= w_busy_n;
            r_done <= w_done_n;
        end
    end

    tone_gen u_tone_gen (
        .clk           (clk),
        .rst           (rst),
        .i_en          (w_tg_en),
        .i_clr         (w_tg_clr),
        .i_half_period (w_tg_hp),
        .i_amp         (w_tg_amp),
        .o_sample      (w_sample)
    );

    assign rom_addr = r_addr;
    assign audio_left = w_sample;
    assign audio_right = w_sample;
    assign busy = r_busy;
    assign done = r_done;
endmodule

// File: doc/tone_sequencer.md
# tone_sequencer

Plays a stored melody by reading note entries from an external synchronous ROM and producing signed 16-bit square-wave samples. It sits directly upstream of the I2S speaker serializer and drives that block's left/right sample inputs. It owns note sequencing: fetch, per-note duration, inter-note gap, looping, pause and stop. The serializer re-samples its inputs at its own rate, so this block only has to hold each sample value stable in the `clk` domain.

## Interface
Parameters:
- `BEAT_CYCLES`, default 12_500_000: `clk` cycles per duration unit (1/8 s at 100 MHz).
- `GAP_CYCLES`, default 1_000_000: silent cycles inserted after every note.
- `ADDR_W`, default 6: ROM address width; depth is 2^ADDR_W.

Ports:
- `clk`  in  1: system clock.
- `rst`  in  1: reset. One clock; reset is synchronous and active-high.
- `start`  in  1: begin playback at entry 0. Honoured only in IDLE.
- `stop`  in  1: abort playback. Honoured in every state.
- `pause`  in  1: level signal. Freezes the note and mutes the output.
- `loop`  in  1: level signal, sampled at the end marker. 1 restarts at entry 0.
- `volume`  in  2: amplitude select, sampled at LOAD.
- `rom_addr`  out  ADDR_W: entry address.
- `rom_data`  in  24: entry contents, valid 1 cycle after `rom_addr`. Fields are {dur[23:20], half_period[19:0]}.
- `audio_left`  out  16: signed sample.
- `audio_right`  out  16: signed sample, always equal to `audio_left`.
- `busy`  out  1: 1 in every state except IDLE.
- `done`  out  1: 1-cycle pulse when playback ends naturally.

## Operation
States:
- **IDLE**: outputs 0. On `start`, set `rom_addr`=0 and go to FETCH.
- **FETCH**: hold `rom_addr` for the ROM latency. Go to LOAD.
- **LOAD**: latch `rom_data`. Entry handling:
  - `dur`=0 is the end marker. If `loop`=1, go to FETCH with `rom_addr`=0. Otherwise go to DONE.
  - Otherwise load the beat counter with `dur` and the cycle counter with 0, set phase high, latch `amp` = 16'h0800 << `volume`, and go to PLAY.
- **PLAY**: sample is +`amp` when phase is high and −`amp` (two's complement) when phase is low.
  - The tone counter counts 0..`half_period`−1 and toggles phase at wrap.
  - `half_period`=0 is a rest: sample 0, no toggling.
  - After exactly `dur`×`BEAT_CYCLES` cycles, go to GAP.
- **GAP**: sample 0 for `GAP_CYCLES` cycles. Then go to FETCH with `rom_addr`+1.
  - If `rom_addr` is already 2^ADDR_W−1, treat it as an end marker and apply the same `loop`/DONE rule as LOAD. Never wrap silently.
- **DONE**: pulse `done`=1 and output 0. Go to IDLE.

Control:
- `stop` returns to IDLE on the next edge from any state. Outputs go to 0 and `done` is not pulsed.
- `stop` has priority over `start` and `pause`.
- `start` while `busy`=1 is ignored.
- `pause`=1 in PLAY or GAP freezes all counters and the phase, and forces the sample to 0. Deasserting `pause` resumes from the frozen point.
- `pause` has no effect in IDLE, FETCH, LOAD or DONE.

## Timing
- Reset values: state IDLE, `rom_addr`=0, `audio_left`=`audio_right`=0, `busy`=0, `done`=0. All counters and the phase register are 0.
- All outputs are registered.
- `start` sampled at edge 0 gives FETCH in cycle 1, LOAD in cycle 2 and the first PLAY sample (+`amp`) in cycle 3. `busy` rises in cycle 1.
- Each played note occupies 2 + `dur`×`BEAT_CYCLES` + `GAP_CYCLES` cycles, excluding paused cycles.
- An end marker costs FETCH + LOAD, then DONE in the next cycle; `done` is high for 1 cycle. `busy` falls the cycle after DONE.
- A square-wave period is 2×`half_period` cycles. Phase restarts high at every note.
- `rst` mid-playback has the same effect as `stop` and also clears all counters.

## Structure
- Package `tone_seq_pkg` holds:
  - the state enum {IDLE, FETCH, LOAD, PLAY, GAP, DONE};
  - the entry field positions and widths (DUR_W=4, HP_W=20);
  - the base amplitude 16'h0800.
- Sub-module `tone_gen` contains the half-period counter, the phase register and sample formation.
  - Inputs: `half_period`, `amp`, enable, clear.
  - Output: sample.
- The top level contains the FSM, the beat/gap counters and the address register.

## Test plan
Bench parameters: `BEAT_CYCLES`=8, `GAP_CYCLES`=2, `ADDR_W`=3, `volume`=0.
1. ROM {dur=1, hp=2}, then end marker; pulse `start` at cycle 0.
   - Cycles 3..10: samples +0x0800, +0x0800, 0xF800, 0xF800, and repeat.
   - Cycles 11–12: 0.
   - `done` pulses at cycle 16; `busy` is 0 from cycle 17.
2. Entry {dur=2, hp=0}: 16 cycles of sample 0 in PLAY, then a normal GAP.
3. `loop`=1 with a 1-note song: after the end marker, `rom_addr` returns to 0, no `done` pulse occurs, and the note replays.
4. `pause` asserted for 5 cycles mid-PLAY: sample is 0 during the pause, and the note ends 5 cycles later than in scenario 1 with the phase continuous. Assert `start` during PLAY: no effect.
5. Assert `stop` and `start` in the same cycle during PLAY: state becomes IDLE on the next edge, outputs are 0, `done` stays 0.
6. All 8 entries have nonzero `dur` and `loop`=0: after entry 7's GAP, the block goes to DONE and `rom_addr` never exceeds 7.
